iso_path_mover: RTL and testbench

Parametrised successor to the single-sprite movement FSM. It moves a sprite one diagonal step per enabled tick along an isometric walkway. Each candidate move is validated against a runtime-programmable table of diagonal path segments, replacing hard-coded walkway equations. Each accepted move is sequenced through the sprite drawer's erase/draw handshake. It supports hold-to-repeat movement and a direct position load for moving platforms and level changes.

---
 rtl/iso_path_mover_pkg.sv | 20 ++
 rtl/iso_path_mover_if.sv | 23 ++
 rtl/iso_path_mover_path_segment_check.sv | 39 +++
 rtl/iso_path_mover.sv | 85 ++++++++
 tb/tb_iso_path_mover.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/iso_path_mover_pkg.sv
// iso_path_mover_pkg: shared encodings, segment field layout and sizing helpers
package iso_path_mover_pkg;
  typedef enum logic [1:0] {DIR_DL = 2'd0, DIR_DR = 2'd1, DIR_UL = 2'd2, DIR_UR = 2'd3} dir_t;
  typedef enum logic [2:0] {IDLE, CALC, CHECK, ERASE_REQ, ERASE_WAIT, UPDATE, DRAW_REQ, DRAW_WAIT} state_t;
  function automatic int clog2(input int v);
    int r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  // Segment word is {valid, slope, C[X_W:0], x_min[X_W-1:0], x_max[X_W-1:0]}
  function automatic int seg_w(input int xw);
    return 3 * xw + 3;
  endfunction
  function automatic int seg_valid_bit(input int xw);
    return 3 * xw + 2;
  endfunction
  function automatic int seg_slope_bit(input int xw);
    return 3 * xw + 1;
  endfunction
endpackage

// File: rtl/iso_path_mover_if.sv
// iso_path_mover_if: control, table-write and drawer handshake bundle for the path mover
interface iso_path_mover_if #(parameter int X_W = 9, parameter int Y_W = 8, parameter int SEG_AW = 3, parameter int SEG_W = 30);
  logic move;
  logic [1:0] dir;
  logic pos_load;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic seg_we;
  logic [SEG_AW-1:0] seg_addr;
  logic [SEG_W-1:0] seg_data;
  logic done_bg;
  logic done_char;
  logic draw_bg;
  logic draw_char;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic busy;
  logic blocked;
  modport master(output move, dir, pos_load, pos_x, pos_y, seg_we, seg_addr, seg_data, done_bg, done_char,
                 input draw_bg, draw_char, x, y, busy, blocked);
  modport slave(input move, dir, pos_load, pos_x, pos_y, seg_we, seg_addr, seg_data, done_bg, done_char,
                output draw_bg, draw_char, x, y, busy, blocked);
endinterface

// File: rtl/iso_path_mover_path_segment_check.sv
// path_segment_check: programmable diagonal segment table with parallel match on a candidate position
module path_segment_check import iso_path_mover_pkg::*; #(
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int NUM_SEG = 8,
  parameter int SEG_AW = clog2(NUM_SEG),
  parameter int SEG_W = seg_w(X_W)
) (
  input  logic clock,
  input  logic resetn,
  input  logic seg_we,
  input  logic [SEG_AW-1:0] seg_addr,
  input  logic [SEG_W-1:0] seg_data,
  input  logic [X_W:0] nx,
  input  logic [Y_W:0] ny,
  output logic match
);
  logic [SEG_W-1:0] tbl [NUM_SEG];
  logic [NUM_SEG-1:0] hit;
  logic signed [X_W+1:0] sx, sy;
  always_ff @(posedge clock) begin
    if (!resetn) for (int i = 0; i < NUM_SEG; i++) tbl[i] <= '0;
    else if (seg_we) tbl[seg_addr] <= seg_data;
  end
  assign sx = signed'({1'b0, nx});
  assign sy = signed'((X_W+2)'(ny));
  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
    logic signed [X_W:0] c_raw;
    logic signed [X_W+1:0] c;
    logic [X_W-1:0] lo, hi;
    assign c_raw = signed'(tbl[g][3*X_W -: X_W+1]);
    assign c = (X_W+2)'(c_raw);
    assign lo = tbl[g][2*X_W-1 -: X_W];
    assign hi = tbl[g][X_W-1:0];
    assign hit[g] = tbl[g][seg_valid_bit(X_W)] && ({1'b0, lo} <= nx) && (nx <= {1'b0, hi}) &&
                    (sy == (tbl[g][seg_slope_bit(X_W)] ? c + sx : c - sx));
  end
  assign match = |hit;
endmodule

// File: rtl/iso_path_mover.sv
// iso_path_mover: tick-paced diagonal sprite mover with path-table validation and erase/draw handshake
module iso_path_mover import iso_path_mover_pkg::*; #(
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int STEP = 1,
  parameter int NUM_SEG = 8,
  parameter int TICK_DIV = 6250000,
  parameter int START_X = 1,
  parameter int START_Y = 16
) (
  input logic clock,
  input logic resetn,
  iso_path_mover_if.slave bus
);
  localparam int SEG_AW = clog2(NUM_SEG);
  localparam int SEG_W = seg_w(X_W);
  localparam int CNT_W = clog2(TICK_DIV);
  state_t state, state_n;
  dir_t dir_q;
  logic [CNT_W-1:0] cnt;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [X_W:0] nx;
  logic [Y_W:0] ny;
  logic tick, match, in_bounds, ok, start;
  assign tick = cnt == CNT_W'(TICK_DIV - 1);
  assign start = !bus.pos_load && bus.move && tick;
  // Extra-bit coordinates make underflow wrap far above the screen limit
  assign in_bounds = nx >= (X_W+1)'(1) && nx <= (X_W+1)'(SCREEN_W - 1) &&
                     ny >= (Y_W+1)'(1) && ny <= (Y_W+1)'(SCREEN_H - 1);
  assign ok = in_bounds && match;
  path_segment_check #(.X_W(X_W), .Y_W(Y_W), .NUM_SEG(NUM_SEG), .SEG_AW(SEG_AW), .SEG_W(SEG_W)) u_seg (
    .clock(clock), .resetn(resetn), .seg_we(bus.seg_we), .seg_addr(bus.seg_addr),
    .seg_data(bus.seg_data), .nx(nx), .ny(ny), .match(match)
  );
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      x_q <= X_W'(START_X);
      y_q <= Y_W'(START_Y);
      nx <= '0;
      ny <= '0;
      dir_q <= DIR_DL;
    end else begin
      state <= state_n;
      cnt <= tick ? '0 : cnt + 1'b1;
      if (state == IDLE && bus.pos_load) begin
        x_q <= bus.pos_x;
        y_q <= bus.pos_y;
      end
      if (state == IDLE && start) dir_q <= dir_t'(bus.dir);
      if (state == CALC) begin
        nx <= dir_q[0] ? {1'b0, x_q} - (X_W+1)'(STEP) : {1'b0, x_q} + (X_W+1)'(STEP);
        ny <= dir_q[1] ? {1'b0, y_q} - (Y_W+1)'(STEP) : {1'b0, y_q} + (Y_W+1)'(STEP);
      end
      if (state == UPDATE) begin
        x_q <= nx[X_W-1:0];
        y_q <= ny[Y_W-1:0];
      end
    end
  end
  always_comb begin
    state_n = state;
    bus.draw_bg = state == ERASE_REQ;
    bus.draw_char = state == DRAW_REQ;
    bus.busy = state != IDLE;
    bus.blocked = state == CHECK && !ok;
    case (state)
      IDLE:       state_n = start ? CALC : IDLE;
      CALC:       state_n = CHECK;
      CHECK:      state_n = ok ? ERASE_REQ : IDLE;
      ERASE_REQ:  state_n = ERASE_WAIT;
      ERASE_WAIT: state_n = bus.done_bg ? UPDATE : ERASE_WAIT;
      UPDATE:     state_n = DRAW_REQ;
      DRAW_REQ:   state_n = DRAW_WAIT;
      DRAW_WAIT:  state_n = bus.done_char ? IDLE : DRAW_WAIT;
      default:    state_n = IDLE;
    endcase
  end
  assign bus.x = x_q;
  assign bus.y = y_q;
endmodule

// File: tb/tb_iso_path_mover.sv
// tb_iso_path_mover: directed scenario bench for the isometric path mover
module tb_iso_path_mover;
  localparam int TD = 10;
  logic clock, resetn;
  int tcnt;
  logic tick_m;
  int n_checks = 0;
  int n_fail = 0;
  iso_path_mover_if #(.X_W(9), .Y_W(8), .SEG_AW(3), .SEG_W(30)) bus ();
  iso_path_mover #(.TICK_DIV(TD)) dut (.clock(clock), .resetn(resetn), .bus(bus.slave));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) tcnt <= !resetn ? 0 : (tcnt == TD - 1 ? 0 : tcnt + 1);
  assign tick_m = tcnt == TD - 1;

  task automatic seg_write(input int a, input logic v, input logic s, input logic signed [9:0] c,
                           input logic [8:0] lo, input logic [8:0] hi);
    @(negedge clock);
    bus.seg_we = 1'b1; bus.seg_addr = 3'(a); bus.seg_data = {v, s, c, lo, hi};
    @(negedge clock);
    bus.seg_we = 1'b0;
  endtask

  task automatic load(input int px, input int py);
    @(negedge clock);
    bus.pos_load = 1'b1; bus.pos_x = 9'(px); bus.pos_y = 8'(py);
    @(negedge clock);
    bus.pos_load = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    @(negedge clock);
    while (!tick_m && n < 2 * TD) begin
      @(negedge clock);
      n++;
    end
  endtask

  // Leaves the bench at the negedge of T+1 after a single requested step
  task automatic step_start(input logic [1:0] d);
    wait_tick();
    bus.dir = d; bus.move = 1'b1;
    @(negedge clock);
    bus.move = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.move = 0; bus.dir = 0; bus.pos_load = 0; bus.pos_x = 0; bus.pos_y = 0;
    bus.seg_we = 0; bus.seg_addr = 0; bus.seg_data = 0; bus.done_bg = 0; bus.done_char = 0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    n_checks++; if (bus.x !== 9'd1) begin n_fail++; $display("FAIL reset_x got %0d want 1", bus.x); end
    n_checks++; if (bus.y !== 8'd16) begin n_fail++; $display("FAIL reset_y got %0d want 16", bus.y); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.draw_bg !== 1'b0) begin n_fail++; $display("FAIL reset_draw_bg got %b want 0", bus.draw_bg); end
    n_checks++; if (bus.draw_char !== 1'b0) begin n_fail++; $display("FAIL reset_draw_char got %b want 0", bus.draw_char); end
    n_checks++; if (bus.blocked !== 1'b0) begin n_fail++; $display("FAIL reset_blocked got %b want 0", bus.blocked); end
  endtask

  task automatic test_empty_table();
    step_start(2'd0);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy got %b want 1", bus.busy); end
    @(negedge clock);
    n_checks++; if (bus.blocked !== 1'b1) begin n_fail++; $display("FAIL empty_blocked got %b want 1", bus.blocked); end
    @(negedge clock);
    n_checks++; if (bus.blocked !== 1'b0) begin n_fail++; $display("FAIL empty_blocked_pulse got %b want 0", bus.blocked); end
    n_checks++; if (bus.draw_bg !== 1'b0) begin n_fail++; $display("FAIL empty_draw_bg got %b want 0", bus.draw_bg); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle got %b want 0", bus.busy); end
    n_checks++; if ({bus.x, bus.y} !== {9'd1, 8'd16}) begin n_fail++; $display("FAIL empty_pos got (%0d,%0d) want (1,16)", bus.x, bus.y); end
  endtask

  task automatic test_step();
    seg_write(0, 1'b1, 1'b0, 10'sd222, 9'd96, 9'd122);
    load(100, 122);
    n_checks++; if ({bus.x, bus.y} !== {9'd100, 8'd122}) begin n_fail++; $display("FAIL load_pos got (%0d,%0d) want (100,122)", bus.x, bus.y); end
    step_start(2'd2);
    @(negedge clock);
    n_checks++; if (bus.blocked !== 1'b0) begin n_fail++; $display("FAIL step_blocked got %b want 0", bus.blocked); end
    @(negedge clock);
    n_checks++; if (bus.draw_bg !== 1'b1) begin n_fail++; $display("FAIL step_draw_bg_t3 got %b want 1", bus.draw_bg); end
    @(negedge clock);
    n_checks++; if (bus.draw_bg !== 1'b0) begin n_fail++; $display("FAIL step_draw_bg_pulse got %b want 0", bus.draw_bg); end
    repeat (2) @(negedge clock);
    n_checks++; if (bus.x !== 9'd100 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL step_wait got x=%0d busy=%b want x=100 busy=1", bus.x, bus.busy); end
    bus.done_bg = 1'b1;
    @(negedge clock);
    bus.done_bg = 1'b0;
    n_checks++; if (bus.x !== 9'd100 || bus.draw_char !== 1'b0) begin n_fail++; $display("FAIL step_d1 got x=%0d draw_char=%b want x=100 draw_char=0", bus.x, bus.draw_char); end
    @(negedge clock);
    n_checks++; if ({bus.x, bus.y} !== {9'd101, 8'd121}) begin n_fail++; $display("FAIL step_pos got (%0d,%0d) want (101,121)", bus.x, bus.y); end
    n_checks++; if (bus.draw_char !== 1'b1) begin n_fail++; $display("FAIL step_draw_char got %b want 1", bus.draw_char); end
    @(negedge clock);
    n_checks++; if (bus.draw_char !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL step_draw_wait got draw_char=%b busy=%b want 0 1", bus.draw_char, bus.busy); end
    bus.done_char = 1'b1;
    @(negedge clock);
    bus.done_char = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL step_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_off_line();
    load(100, 122);
    step_start(2'd0);
    @(negedge clock);
    n_checks++; if (bus.blocked !== 1'b1) begin n_fail++; $display("FAIL offline_blocked got %b want 1", bus.blocked); end
    @(negedge clock);
    n_checks++; if (bus.draw_bg !== 1'b0) begin n_fail++; $display("FAIL offline_draw_bg got %b want 0", bus.draw_bg); end
    n_checks++; if ({bus.x, bus.y} !== {9'd100, 8'd122}) begin n_fail++; $display("FAIL offline_pos got (%0d,%0d) want (100,122)", bus.x, bus.y); end
  endtask

  task automatic test_bounds();
    seg_write(1, 1'b1, 1'b1, 10'sd51, 9'd0, 9'd0);
    load(1, 50);
    step_start(2'd1);
    @(negedge clock);
    n_checks++; if (bus.blocked !== 1'b1) begin n_fail++; $display("FAIL underflow_blocked got %b want 1", bus.blocked); end
    @(negedge clock);
    n_checks++; if (bus.draw_bg !== 1'b0 || bus.x !== 9'd1) begin n_fail++; $display("FAIL underflow_hold got draw_bg=%b x=%0d want 0 1", bus.draw_bg, bus.x); end
    seg_write(2, 1'b1, 1'b1, -10'sd219, 9'd0, 9'd511);
    load(319, 100);
    step_start(2'd0);
    @(negedge clock);
    n_checks++; if (bus.blocked !== 1'b1) begin n_fail++; $display("FAIL overflow_blocked got %b want 1", bus.blocked); end
    @(negedge clock);
    n_checks++; if (bus.draw_bg !== 1'b0 || bus.x !== 9'd319) begin n_fail++; $display("FAIL overflow_hold got draw_bg=%b x=%0d want 0 319", bus.draw_bg, bus.x); end
  endtask

  task automatic test_hold_repeat();
    int draws = 0;
    int blocks = 0;
    bit seen = 0;
    load(96, 126);
    bus.done_bg = 1'b1; bus.done_char = 1'b1;
    wait_tick();
    bus.dir = 2'd2; bus.move = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (bus.draw_char) draws++;
      if (bus.blocked) blocks++;
      if (bus.x == 9'd122 && !bus.busy) break;
    end
    n_checks++; if ({bus.x, bus.y} !== {9'd122, 8'd100}) begin n_fail++; $display("FAIL hold_end got (%0d,%0d) want (122,100)", bus.x, bus.y); end
    n_checks++; if (draws !== 26) begin n_fail++; $display("FAIL hold_draws got %0d want 26", draws); end
    n_checks++; if (blocks !== 0) begin n_fail++; $display("FAIL hold_blocks got %0d want 0", blocks); end
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clock);
      if (bus.blocked) begin seen = 1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL hold_edge_blocked got %b want 1", seen); end
    bus.move = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++; if ({bus.x, bus.y} !== {9'd122, 8'd100}) begin n_fail++; $display("FAIL hold_edge_pos got (%0d,%0d) want (122,100)", bus.x, bus.y); end
    bus.done_bg = 1'b0; bus.done_char = 1'b0;
  endtask

  task automatic test_reset_mid();
    int draws = 0;
    load(100, 122);
    step_start(2'd2);
    repeat (3) @(negedge clock);
    n_checks++; if (bus.busy !== 1'b1 || bus.draw_bg !== 1'b0) begin n_fail++; $display("FAIL mid_erase_wait got busy=%b draw_bg=%b want 1 0", bus.busy, bus.draw_bg); end
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    n_checks++; if ({bus.x, bus.y} !== {9'd1, 8'd16}) begin n_fail++; $display("FAIL mid_pos got (%0d,%0d) want (1,16)", bus.x, bus.y); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    bus.done_bg = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bus.done_bg = 1'b0;
      if (bus.draw_char) draws++;
    end
    n_checks++; if (draws !== 0) begin n_fail++; $display("FAIL mid_draw_char got %0d want 0", draws); end
    load(100, 122);
    step_start(2'd2);
    @(negedge clock);
    n_checks++; if (bus.blocked !== 1'b1) begin n_fail++; $display("FAIL mid_table_cleared got %b want 1", bus.blocked); end
  endtask

  initial begin
    test_reset();
    test_empty_table();
    test_step();
    test_off_line();
    test_bounds();
    test_hold_repeat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end
endmodule
